rf_scrub_scheduler: RTL

Parametrised read-port scrubbing scheduler for the ID/OP boundary. Each cycle it finds the register-file read ports that the instruction in flight does not need. It drives scrub addresses onto those ports so that accumulated SEUs in the register file are found without stalling the pipeline. Compared with the previous fixed two-port scheme, it adds:
- configurable port count and address range;
- an independent-pointer per-port mode;
- a starvation-driven restart request;
- sweep-completion reporting.

---
 rtl/p_hardisc.sv | 23 ++
 rtl/scrub_ptr.sv | 33 +++
 rtl/rf_scrub_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/p_hardisc.sv
// Shared definitions for the register-file scrub scheduler.
// Mode encoding, default range start and pointer reset helper.
package p_hardisc;

   typedef enum logic [1:0] {
      SCRUB_OFF        = 2'b00,
      SCRUB_SHARED     = 2'b01,
      SCRUB_SHARED_RST = 2'b10,
      SCRUB_PERPORT    = 2'b11
   } scrub_mode;

   localparam int SCRUB_FIRST_DEF = 1;

   // Start value of port p, folded into [first, last].
   function automatic int scrub_rst_val(
      input int first,
      input int last,
      input int p
   );
      return first + (p % (last - first + 1));
   endfunction

endpackage

// File: rtl/scrub_ptr.sv
// Wrapping scrub address counter over [FIRST, LAST].
// Emits a wrap pulse in the cycle it steps from LAST back to FIRST.
module scrub_ptr
   import p_hardisc::*;
#(
   parameter int AW     = 5,
   parameter int FIRST  = SCRUB_FIRST_DEF,
   parameter int LAST   = 31,
   parameter int RSTVAL = FIRST
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          wrap,
   output logic [AW-1:0] value
);

   logic [AW-1:0] value_q;

   assign wrap  = enable & (value_q == AW'(LAST));
   assign value = value_q;

   // Step the address, folding LAST back to FIRST.
   always_ff @(posedge clk) begin
      if (reset)
         value_q <= AW'(RSTVAL);
      else if (wrap)
         value_q <= AW'(FIRST);
      else if (enable)
         value_q <= value_q + 1'b1;
   end

endmodule

// File: rtl/rf_scrub_scheduler.sv
// Read-port scrub scheduler: idle RF read ports carry scrub reads.
// Tracks sweeps and requests a restart when scrubbing starves.
module rf_scrub_scheduler
   import p_hardisc::*;
#(
   parameter int RP       = 2,
   parameter int AW       = 5,
   parameter int FIRST    = SCRUB_FIRST_DEF,
   parameter int LAST     = 31,
   parameter int STARVE_W = 4,
   parameter int SWEEP_W  = 8
) (
   input  logic                   s_clk_i,
   input  logic                   s_reset_i,
   input  logic [1:0]             s_mode_i,
   input  logic                   s_flush_i,
   input  logic                   s_stall_i,
   input  logic                   s_nop_i,
   input  logic [RP-1:0]          s_id_free_i,
   input  logic [RP-1:0]          s_op_free_i,
   output logic [RP-1:0][AW-1:0]  s_scrub_add_o,
   output logic [RP-1:0]          s_scrub_use_o,
   output logic                   s_restart_o,
   output logic                   s_sweep_done_o,
   output logic [SWEEP_W-1:0]     s_sweep_cnt_o
);

   scrub_mode mode;
   logic [1:0] mode_q;
   logic mode_chg;
   logic shared;

   logic [RP-1:0] free;
   logic [RP-1:0] adv;
   logic [RP-1:0] wrap;
   logic [RP-1:0][AW-1:0] ptr;

   logic [RP-1:0] sticky_q;
   logic [RP-1:0] sticky_b;
   logic [RP-1:0] sticky_n;
   logic done_n;
   logic done_q;
   logic [SWEEP_W-1:0] cnt_q;

   logic [STARVE_W-1:0] starve_q;
   logic [STARVE_W-1:0] starve_n;

   assign mode     = scrub_mode'(s_mode_i);
   assign mode_chg = (s_mode_i != mode_q);
   assign shared   = (mode == SCRUB_SHARED) | (mode == SCRUB_SHARED_RST);

   assign s_restart_o = (starve_q == '1) & s_mode_i[1]
                      & ~s_flush_i & ~s_reset_i;

   assign s_sweep_done_o = done_q;
   assign s_sweep_cnt_o  = cnt_q;

   // Port freedom, scrub use and pointer advance per mode.
   always_comb begin
      free = '0;
      adv  = '0;
      for (int p = 0; p < RP; p++) begin
         free[p] = s_flush_i | s_restart_o
                 | (s_stall_i & s_op_free_i[p])
                 | (~s_stall_i & (s_id_free_i[p] | s_nop_i));
      end
      s_scrub_use_o = (mode != SCRUB_OFF && !s_reset_i) ? free : '0;
      unique case (mode)
         SCRUB_OFF:        adv = '0;
         SCRUB_SHARED,
         SCRUB_SHARED_RST: adv[0] = |free;
         SCRUB_PERPORT:    adv = free;
      endcase
   end

   // Shared modes broadcast pointer 0 to every port.
   always_comb begin
      s_scrub_add_o = '0;
      for (int p = 0; p < RP; p++)
         s_scrub_add_o[p] = shared ? ptr[0] : ptr[p];
   end

   // Sweep completion and sticky wrap bookkeeping.
   always_comb begin
      sticky_b = mode_chg ? '0 : sticky_q;
      sticky_n = sticky_b | wrap;
      done_n   = 1'b0;
      if (mode == SCRUB_PERPORT) begin
         if (&(sticky_b | wrap)) begin
            done_n   = 1'b1;
            sticky_n = sticky_b & wrap;
         end
      end else if (wrap[0]) begin
         done_n = 1'b1;
      end
   end

   // Starvation counts idle cycles while a restart mode is active.
   always_comb begin
      if (mode_chg || !s_mode_i[1] || (|adv))
         starve_n = '0;
      else
         starve_n = starve_q + 1'b1;
   end

   genvar gp;
   generate
      for (gp = 0; gp < RP; gp++) begin : g_ptr
         scrub_ptr #(
            .AW     (AW),
            .FIRST  (FIRST),
            .LAST   (LAST),
            .RSTVAL (scrub_rst_val(FIRST, LAST, gp))
         ) u_ptr (
            .clk    (s_clk_i),
            .reset  (s_reset_i),
            .enable (adv[gp]),
            .wrap   (wrap[gp]),
            .value  (ptr[gp])
         );
      end
   endgenerate

   // Previous mode follows the input even in reset, so no false change.
   always_ff @(posedge s_clk_i) begin
      mode_q <= s_mode_i;
   end

   // Sweep, starvation and sticky state.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         sticky_q <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         sticky_q <= sticky_n;
         done_q   <= done_n;
         starve_q <= starve_n;
         if (done_n && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule
